// File: rtl/hilo_pkg.sv
// Shared types and default latencies for the HI/LO result stage.
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_WAIT  = 2'd1,
    MULT_WAIT = 2'd2
  } hilo_state_t;

  localparam int DIV_LATENCY_DEF  = 20;
  localparam int MULT_LATENCY_DEF = 4;

endpackage

// File: rtl/hilo_latency_cnt.sv
// Cycle counter for the fixed unit latency; saturates at the target and
// reports done while enabled and the target has been reached.
module hilo_latency_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != target)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = enable && (cnt_q == target);
  assign cnt  = cnt_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO result stage: starts div/mult, times their latency, captures results,
// and serves MFHI/MFLO/MTHI/MTLO with a stall while a result is pending.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        hilorst,
  input  logic        start_div,
  input  logic        start_mult,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic        divrst,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall
);

  hilo_state_t      state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             div_pulse_q, div_pulse_d;
  logic             cnt_clear;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_target;
  logic [CNT_W-1:0] cnt_val;

  logic accept_div, accept_mult, mt_wr;

  // Divide wins over multiply when both are requested together.
  assign accept_div  = start_div;
  assign accept_mult = start_mult && !start_div;
  assign mt_wr       = mthi || mtlo;
  assign busy        = (state_q != IDLE);

  assign cnt_target = (state_q == MULT_WAIT) ? CNT_W'(MULT_LATENCY) : CNT_W'(DIV_LATENCY);

  hilo_latency_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (hilorst),
    .clear  (cnt_clear),
    .enable (busy),
    .target (cnt_target),
    .done   (cnt_done),
    .cnt    (cnt_val)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_clear   = 1'b0;
    div_pulse_d = accept_div;

    // A capture only lands if nothing in this cycle aborts the op.
    if (cnt_done && !start_div && !start_mult && !mt_wr) begin
      if (state_q == DIV_WAIT) begin
        lo_d = div_q;
        hi_d = div_r;
      end else begin
        hi_d = mult_hi;
        lo_d = mult_lo;
      end
      state_d   = IDLE;
      cnt_clear = 1'b1;
    end

    if (mthi) hi_d = wdata;
    if (mtlo) lo_d = wdata;
    if (mt_wr && busy) begin
      state_d   = IDLE;
      cnt_clear = 1'b1;
    end

    if (accept_div) begin
      state_d   = DIV_WAIT;
      cnt_clear = 1'b1;
    end else if (accept_mult) begin
      state_d   = MULT_WAIT;
      cnt_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge hilorst) begin
    if (hilorst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      div_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_pulse_q <= div_pulse_d;
    end
  end

  assign divrst = hilorst || div_pulse_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign rdata  = mfhi ? hi_q : (mflo ? lo_q : 32'd0);
  assign stall  = (mfhi || mflo) && busy;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; inputs change and outputs are
// sampled 1 ns after the rising edge.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        hilorst;
  logic        start_div, start_mult;
  logic [31:0] div_q, div_r, mult_hi, mult_lo;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        mfhi, mflo;
  logic        divrst;
  logic [31:0] hi, lo, rdata;
  logic        busy, stall;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_unit dut (
    .clk        (clk),
    .hilorst    (hilorst),
    .start_div  (start_div),
    .start_mult (start_mult),
    .div_q      (div_q),
    .div_r      (div_r),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .mfhi       (mfhi),
    .mflo       (mflo),
    .divrst     (divrst),
    .hi         (hi),
    .lo         (lo),
    .rdata      (rdata),
    .busy       (busy),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles after the accepting edge, bounded at 60.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      tick();
    end
  endtask

  int n;
  bit early;

  initial begin
    hilorst = 1'b1; start_div = 0; start_mult = 0;
    div_q = 0; div_r = 0; mult_hi = 0; mult_lo = 0;
    mthi = 0; mtlo = 0; wdata = 0; mfhi = 0; mflo = 0;
    #2;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_divrst", {31'd0, divrst}, 32'd1);
    tick();
    hilorst = 1'b0;
    tick();
    check("idle_divrst", {31'd0, divrst}, 32'd0);

    // 7/2 unsigned division
    div_q = 32'd3; div_r = 32'd1; start_div = 1;
    tick();
    start_div = 0;
    check("div_pulse_on", {31'd0, divrst}, 32'd1);
    check("div_busy_on", {31'd0, busy}, 32'd1);
    tick();
    check("div_pulse_off", {31'd0, divrst}, 32'd0);
    count_busy(n);
    check("div_busy_cycles", n, 32'd20);  // one busy cycle already consumed above
    check("div_lo", lo, 32'd3);
    check("div_hi", hi, 32'd1);

    // Reset while cnt==7
    div_q = 32'd77; div_r = 32'd55; start_div = 1;
    tick();
    start_div = 0;
    repeat (7) tick();
    hilorst = 1'b1;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_divrst", {31'd0, divrst}, 32'd1);
    tick();
    hilorst = 1'b0;
    repeat (30) tick();
    check("midrst_no_capture_lo", lo, 32'd0);
    check("midrst_no_capture_busy", {31'd0, busy}, 32'd0);

    // -7/2 signed with mflo held throughout
    div_q = 32'hFFFF_FFFD; div_r = 32'hFFFF_FFFF; start_div = 1; mflo = 1;
    tick();
    start_div = 0;
    check("sdiv_stall_on", {31'd0, stall}, 32'd1);
    check("sdiv_rdata_old", rdata, 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    check("sdiv_stall_cycles", n, 32'd21);
    check("sdiv_rdata", rdata, 32'hFFFF_FFFD);
    check("sdiv_hi", hi, 32'hFFFF_FFFF);
    mflo = 0;

    // Multiply
    mult_hi = 32'h1; mult_lo = 32'h8000_0000; start_mult = 1;
    tick();
    start_mult = 0;
    check("mult_divrst", {31'd0, divrst}, 32'd0);
    count_busy(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_hi", hi, 32'h1);
    check("mult_lo", lo, 32'h8000_0000);

    // Simultaneous start: divide only
    div_q = 32'd11; div_r = 32'd22; mult_hi = 32'hAAAA; mult_lo = 32'hBBBB;
    start_div = 1; start_mult = 1;
    tick();
    start_div = 0; start_mult = 0;
    check("both_divrst", {31'd0, divrst}, 32'd1);
    count_busy(n);
    check("both_busy_cycles", n, 32'd21);
    check("both_lo", lo, 32'd11);
    check("both_hi", hi, 32'd22);

    // Restart at cnt==10
    div_q = 32'd5; div_r = 32'd0; start_div = 1;
    tick();
    start_div = 0;
    repeat (10) tick();
    div_q = 32'd9; start_div = 1;
    tick();
    start_div = 0;
    check("restart_divrst", {31'd0, divrst}, 32'd1);
    n = 0; early = 0;
    while (busy === 1'b1 && n < 60) begin
      if (lo !== 32'd11) early = 1;
      n++;
      tick();
    end
    check("restart_busy_cycles", n, 32'd21);
    check("restart_no_early", {31'd0, early}, 32'd0);
    check("restart_lo", lo, 32'd9);

    // MTHI aborts a pending divide
    div_q = 32'd1234; div_r = 32'd5678; start_div = 1;
    tick();
    start_div = 0;
    repeat (3) tick();
    mthi = 1; wdata = 32'hDEAD_BEEF;
    tick();
    mthi = 0;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'd9);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    repeat (25) tick();
    check("mthi_no_capture", hi, 32'hDEAD_BEEF);

    // MTHI+MTLO together, then read priority
    mthi = 1; mtlo = 1; wdata = 32'h1234_5678;
    tick();
    mthi = 0; mtlo = 0;
    check("mt_both_hi", hi, 32'h1234_5678);
    check("mt_both_lo", lo, 32'h1234_5678);
    mtlo = 1; wdata = 32'h0000_00AB;
    tick();
    mtlo = 0;
    mfhi = 1; mflo = 1;
    #1;
    check("rd_prio_hi", rdata, 32'h1234_5678);
    mfhi = 0;
    #1;
    check("rd_lo", rdata, 32'h0000_00AB);
    mflo = 0;
    #1;
    check("rd_none", rdata, 32'd0);
    check("rd_no_stall", {31'd0, stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
